// File: rtl/zxuno_regs_pkg.sv
// Shared constants for the ZX-UNO register bus: the two Z80 I/O ports,
// the front-end FSM state encoding and the register numbers, so that the
// front end and every register peripheral agree on the same values.
package zxuno_regs_pkg;

  // Z80 I/O ports of the register bus (full 16-bit decode)
  localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

  // Register numbers written to the address port
  localparam logic [7:0] REG_MASTER_CONF   = 8'h00;
  localparam logic [7:0] REG_MASTER_MAPPER = 8'h01;
  localparam logic [7:0] REG_FLASH_SPI     = 8'h02;
  localparam logic [7:0] REG_FLASH_CS      = 8'h03;
  localparam logic [7:0] REG_SCANDBL_CTRL  = 8'h0B;
  localparam logic [7:0] REG_SCRATCH       = 8'hFE;
  localparam logic [7:0] REG_COREID        = 8'hFF;

  // Front-end access sequencer
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_HOLD    = 3'd4
  } regport_state_e;

  // True when the Z80 address bus selects the given I/O port
  function automatic logic port_hit(input logic [15:0] addr,
                                    input logic [15:0] port);
    return addr == port;
  endfunction

endpackage

// File: rtl/zxuno_regport_sync2.sv
// Two-flop synchroniser with a selectable preset value, used to bring the
// asynchronous Z80 strobes into the clk domain.
module sync2 #(
  parameter logic PRESET = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the input through the two synchroniser stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, preset to the inactive level on reset
  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge, giving a true two-stage shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= PRESET;
      sync_q <= PRESET;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/zxuno_regport.sv
// Z80-facing front end of the ZX-UNO register bus. Decodes the address
// and data ports, holds the selected register number, turns each data-port
// access into a single-clock strobe and steers read data onto the CPU bus.
module zxuno_regport
  import zxuno_regs_pkg::*;
#(
  parameter logic [15:0] ADDR_PORT  = ZXUNO_ADDR_PORT,
  parameter logic [15:0] DATA_PORT  = ZXUNO_DATA_PORT,
  parameter logic [7:0]  ADDR_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        poweron_rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regwr,
  output logic        zxuno_regrd,
  output logic        zxuno_regrd_pulse,
  output logic [7:0]  zxuno_dout,
  input  logic [7:0]  reg_din,
  input  logic        reg_oe_n
);

  logic iorq_n_s;
  logic rd_n_s;
  logic wr_n_s;

  sync2 #(.PRESET(1'b1)) u_sync_iorq (
    .clk (clk),
    .rst (poweron_rst),
    .d   (iorq_n),
    .q   (iorq_n_s)
  );

  sync2 #(.PRESET(1'b1)) u_sync_rd (
    .clk (clk),
    .rst (poweron_rst),
    .d   (rd_n),
    .q   (rd_n_s)
  );

  sync2 #(.PRESET(1'b1)) u_sync_wr (
    .clk (clk),
    .rst (poweron_rst),
    .d   (wr_n),
    .q   (wr_n_s)
  );

  logic hit_addr;
  logic hit_data;
  logic wr_act;
  logic rd_act;

  assign hit_addr = port_hit(a, ADDR_PORT);
  assign hit_data = port_hit(a, DATA_PORT);
  assign wr_act   = ~iorq_n_s & ~wr_n_s;
  assign rd_act   = ~iorq_n_s & ~rd_n_s;

  regport_state_e state_q, state_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     dout_q, dout_d;
  logic           regwr_q, regwr_d;
  logic           regrd_q, regrd_d;
  logic           rd_pulse_q, rd_pulse_d;

  // Next-state and next-output logic of the access sequencer; strobes are
  // only raised on the way out of IDLE, so one Z80 cycle gives one pulse
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    regrd_d    = regrd_q;
    regwr_d    = 1'b0;
    rd_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A write wins over a simultaneous (illegal) read
        if (wr_act) begin
          if (hit_addr) begin
            state_d = ST_WR_ADDR;
            addr_d  = cpu_din;
          end else if (hit_data) begin
            state_d = ST_WR_DATA;
            dout_d  = cpu_din;
            regwr_d = 1'b1;
          end
        end else if (rd_act && hit_data) begin
          state_d    = ST_RD_DATA;
          rd_pulse_d = 1'b1;
          regrd_d    = 1'b1;
        end
      end
      ST_WR_ADDR, ST_WR_DATA, ST_RD_DATA: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Wait for the Z80 to release its strobes before re-arming
        if (!wr_act && !rd_act) begin
          state_d = ST_IDLE;
          regrd_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        regrd_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered bus outputs
  always_ff @(posedge clk or posedge poweron_rst) begin
    if (poweron_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_RESET;
      dout_q     <= 8'h00;
      regwr_q    <= 1'b0;
      regrd_q    <= 1'b0;
      rd_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      regwr_q    <= regwr_d;
      regrd_q    <= regrd_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign zxuno_addr        = addr_q;
  assign zxuno_dout        = dout_q;
  assign zxuno_regwr       = regwr_q;
  assign zxuno_regrd       = regrd_q;
  assign zxuno_regrd_pulse = rd_pulse_q;

  // CPU read-data steering straight from the raw strobes, so the bus is
  // driven for exactly as long as the Z80 holds the read
  always_comb begin
    cpu_dout = 8'hFF;
    cpu_oe_n = 1'b1;
    if (!iorq_n && !rd_n) begin
      if (hit_addr) begin
        cpu_dout = addr_q;
        cpu_oe_n = 1'b0;
      end else if (hit_data) begin
        cpu_dout = reg_din;
        cpu_oe_n = reg_oe_n;
      end
    end
  end

endmodule

// File: tb/tb_zxuno_regport.sv
// Directed bench for zxuno_regport with a scoreboard of expected register
// bus writes and reads, popped whenever the DUT raises a strobe.
module tb_zxuno_regport;
  import zxuno_regs_pkg::*;

  logic        clk;
  logic        poweron_rst;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_oe_n;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regwr;
  logic        zxuno_regrd;
  logic        zxuno_regrd_pulse;
  logic [7:0]  zxuno_dout;
  logic [7:0]  reg_din;
  logic        reg_oe_n;

  zxuno_regport dut (
    .clk               (clk),
    .poweron_rst       (poweron_rst),
    .a                 (a),
    .iorq_n            (iorq_n),
    .rd_n              (rd_n),
    .wr_n              (wr_n),
    .cpu_din           (cpu_din),
    .cpu_dout          (cpu_dout),
    .cpu_oe_n          (cpu_oe_n),
    .zxuno_addr        (zxuno_addr),
    .zxuno_regwr       (zxuno_regwr),
    .zxuno_regrd       (zxuno_regrd),
    .zxuno_regrd_pulse (zxuno_regrd_pulse),
    .zxuno_dout        (zxuno_dout),
    .reg_din           (reg_din),
    .reg_oe_n          (reg_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t    wq[$];
  logic [7:0] rq[$];
  wr_exp_t    e_mon;
  logic [7:0] ea_mon;
  logic [7:0] model_addr;

  int compared   = 0;
  int mismatched = 0;
  int wr_pulses  = 0;
  int rd_pulses  = 0;
  int base;

  logic regwr_prev = 1'b0;
  logic pulse_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation
  always @(negedge clk) begin
    if (poweron_rst) begin
      regwr_prev = 1'b0;
      pulse_prev = 1'b0;
    end else begin
      if (zxuno_regwr) begin
        if (regwr_prev) check("regwr_width", 32'(regwr_prev), 32'(0));
        else begin
          wr_pulses++;
          check("wr_expected", 32'(wq.size() != 0), 32'(1));
          if (wq.size() != 0) begin
            e_mon = wq.pop_front();
            check("wr_dout", 32'(zxuno_dout), 32'(e_mon.data));
            check("wr_addr", 32'(zxuno_addr), 32'(e_mon.addr));
          end
        end
      end
      if (zxuno_regrd_pulse) begin
        if (pulse_prev) check("rdpulse_width", 32'(pulse_prev), 32'(0));
        else begin
          rd_pulses++;
          check("rd_expected", 32'(rq.size() != 0), 32'(1));
          if (rq.size() != 0) begin
            ea_mon = rq.pop_front();
            check("rd_addr", 32'(zxuno_addr), 32'(ea_mon));
            check("rd_level", 32'(zxuno_regrd), 32'(1));
          end
        end
      end
      regwr_prev = zxuno_regwr;
      pulse_prev = zxuno_regrd_pulse;
    end
  end

  // Start an I/O write at posedge+2; the next posedge is E0
  task automatic out_start(input logic [15:0] port, input logic [7:0] data, input bit expect_pulse);
    @(posedge clk);
    #2;
    a = port; cpu_din = data; iorq_n = 1'b0; wr_n = 1'b0;
    if (expect_pulse) wq.push_back('{model_addr, data});
    if (port == ZXUNO_ADDR_PORT) model_addr = data;
  endtask

  task automatic io_write(input logic [15:0] port, input logic [7:0] data, input int low);
    out_start(port, data, port == ZXUNO_DATA_PORT);
    repeat (low) @(posedge clk);
    #2;
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    cpu_din = 8'h00; reg_din = 8'h00; reg_oe_n = 1'b1;
    model_addr = 8'h00;
    poweron_rst = 1'b1;
    #1;
    check("rst_addr", 32'(zxuno_addr), 32'(8'h00));
    check("rst_dout", 32'(zxuno_dout), 32'(8'h00));
    check("rst_regwr", 32'(zxuno_regwr), 32'(0));
    check("rst_regrd", 32'(zxuno_regrd), 32'(0));
    check("rst_rdpulse", 32'(zxuno_regrd_pulse), 32'(0));
    check("rst_oe_n", 32'(cpu_oe_n), 32'(1));
    repeat (3) @(posedge clk);
    #2 poweron_rst = 1'b0;
    repeat (2) @(posedge clk);

    // Select register FEh, then write 5Ah with edge-exact strobe timing
    io_write(ZXUNO_ADDR_PORT, REG_SCRATCH, 3);
    repeat (4) @(posedge clk);
    #1 check("sel_addr", 32'(zxuno_addr), 32'(8'hFE));
    base = wr_pulses;
    out_start(ZXUNO_DATA_PORT, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check($sformatf("regwr_e%0d", i), 32'(zxuno_regwr), 32'(i == 2));
      if (i == 2) begin
        check("dout_e2", 32'(zxuno_dout), 32'(8'h5A));
        #1 iorq_n = 1'b1; wr_n = 1'b1;
      end
    end
    repeat (4) @(posedge clk);
    #1 check("wr_single", 32'(wr_pulses - base), 32'(1));

    // IN (FC3Bh): register number on the bus during the strobe only
    @(posedge clk);
    #2 a = ZXUNO_ADDR_PORT; iorq_n = 1'b0; rd_n = 1'b0;
    #1 check("inaddr_oe_n", 32'(cpu_oe_n), 32'(0));
    check("inaddr_dout", 32'(cpu_dout), 32'(8'hFE));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("inaddr_no_regrd", 32'(zxuno_regrd), 32'(0));
    end
    #1 iorq_n = 1'b1; rd_n = 1'b1;
    #1 check("inaddr_release", 32'(cpu_oe_n), 32'(1));
    repeat (4) @(posedge clk);

    // IN (FD3Bh) with a driving peripheral
    base = rd_pulses;
    reg_din = 8'hA5; reg_oe_n = 1'b0;
    @(posedge clk);
    #2 a = ZXUNO_DATA_PORT; iorq_n = 1'b0; rd_n = 1'b0;
    rq.push_back(model_addr);
    #1 check("indata_dout", 32'(cpu_dout), 32'(8'hA5));
    check("indata_oe_n", 32'(cpu_oe_n), 32'(0));
    repeat (3) @(posedge clk);
    #1 check("indata_regrd", 32'(zxuno_regrd), 32'(1));
    #1 iorq_n = 1'b1; rd_n = 1'b1;
    #1 check("indata_release", 32'(cpu_oe_n), 32'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("regrd_fall_f%0d", i), 32'(zxuno_regrd), 32'(i < 2));
    end
    repeat (2) @(posedge clk);
    #1 check("rd_single", 32'(rd_pulses - base), 32'(1));

    // Unimplemented register leaves the CPU bus floating
    reg_oe_n = 1'b1;
    @(posedge clk);
    #2 a = ZXUNO_DATA_PORT; iorq_n = 1'b0; rd_n = 1'b0;
    rq.push_back(model_addr);
    #1 check("float_oe_n", 32'(cpu_oe_n), 32'(1));
    repeat (3) @(posedge clk);
    #2 iorq_n = 1'b1; rd_n = 1'b1;
    repeat (5) @(posedge clk);

    // Long OUT then a 2-clk gap then another OUT: two pulses
    base = wr_pulses;
    io_write(ZXUNO_DATA_PORT, 8'h11, 20);
    @(posedge clk);
    io_write(ZXUNO_DATA_PORT, 8'h22, 3);
    repeat (5) @(posedge clk);
    #1 check("b2b_pulses", 32'(wr_pulses - base), 32'(2));
    check("b2b_dout", 32'(zxuno_dout), 32'(8'h22));

    // Reset during WR_DATA
    out_start(ZXUNO_DATA_PORT, 8'h77, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("prerst_regwr", 32'(zxuno_regwr), 32'(1));
    #2 poweron_rst = 1'b1;
    #1 check("midrst_regwr", 32'(zxuno_regwr), 32'(0));
    check("midrst_dout", 32'(zxuno_dout), 32'(8'h00));
    check("midrst_addr", 32'(zxuno_addr), 32'(8'h00));
    model_addr = 8'h00;
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 poweron_rst = 1'b0;
    base = wr_pulses;
    repeat (8) @(posedge clk);
    #1 check("postrst_idle", 32'(wr_pulses - base), 32'(0));
    io_write(ZXUNO_DATA_PORT, 8'h33, 3);
    repeat (5) @(posedge clk);
    #1 check("postrst_single", 32'(wr_pulses - base), 32'(1));
    check("postrst_dout", 32'(zxuno_dout), 32'(8'h33));

    // Simultaneous read and write: the write wins
    base = rd_pulses;
    out_start(ZXUNO_DATA_PORT, 8'h44, 1'b1);
    rd_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("rw_no_read", 32'(rd_pulses - base), 32'(0));
    check("rw_dout", 32'(zxuno_dout), 32'(8'h44));

    // Accesses to other ports are ignored
    base = wr_pulses;
    io_write(16'h00FE, 8'h99, 3);
    @(posedge clk);
    #2 a = 16'hFC3C; iorq_n = 1'b0; rd_n = 1'b0;
    #1 check("other_oe_n", 32'(cpu_oe_n), 32'(1));
    repeat (3) @(posedge clk);
    #2 iorq_n = 1'b1; rd_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("other_no_wr", 32'(wr_pulses - base), 32'(0));
    check("other_addr", 32'(zxuno_addr), 32'(8'h00));

    check("wq_drained", 32'(wq.size()), 32'(0));
    check("rq_drained", 32'(rq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
